fwrisc_mds_issue: RTL

- Issue/writeback sequencer on the core side of the multi-cycle mul/div/shift (MDS) unit interface.
- Accepts one decoded RV32I-shift / RV32M request at a time and maps it to an MDS op code.
- Pulses the MDS in_valid strobe, waits for out_valid, then presents the result to register writeback.
- Resolves RISC-V corner cases locally without issuing (divide-by-zero, signed overflow, zero shift, unsupported funct3); a watchdog protects against a stuck unit.

---
 rtl/fwrisc_mds_issue.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fwrisc_mds_issue.sv
// fwrisc_mds_issue: core-side issue/writeback sequencer for the multi-cycle
// mul/div/shift (MDS) unit. Decodes one RV32I-shift / RV32M request at a time,
// resolves RISC-V corner cases locally, otherwise pulses the MDS and waits for
// its result (guarded by a saturating watchdog).
// MDS op encoding: SLL=0 SRL=1 SRA=2 MULS=3 MULSH=4 MULH=5 DIV=6 REM=7.
module fwrisc_mds_issue #(
   parameter int unsigned TIMEOUT_CYCLES    = 40,
   parameter bit          BYPASS_ZERO_SHIFT = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_kind,
   input  logic [2:0]  req_funct3,
   input  logic        req_alt,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [4:0]  req_rd,
   output logic [31:0] mds_in_a,
   output logic [31:0] mds_in_b,
   output logic [3:0]  mds_op,
   output logic        mds_in_valid,
   input  logic [31:0] mds_out,
   input  logic        mds_out_valid,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_err,
   output logic        busy
);

   localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0] OP_SLL   = 4'd0;
   localparam logic [3:0] OP_SRL   = 4'd1;
   localparam logic [3:0] OP_SRA   = 4'd2;
   localparam logic [3:0] OP_MULS  = 4'd3;
   localparam logic [3:0] OP_MULSH = 4'd4;
   localparam logic [3:0] OP_MULH  = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_REM   = 4'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state;
   logic [WDW-1:0] wdog;

   logic [3:0]  dec_op;
   logic [31:0] dec_b;
   logic [31:0] dec_data;
   logic        dec_issue;
   logic        dec_err;
   logic        rs2_zero;
   logic        div_ovf;

   // Decode the presented request into an MDS op or a locally resolved result
   always_comb begin
      dec_op    = '0;
      dec_b     = req_rs2;
      dec_data  = '0;
      dec_issue = 1'b0;
      dec_err   = 1'b0;
      rs2_zero  = (req_rs2 == '0);
      div_ovf   = (req_rs1 == 32'h8000_0000) && (req_rs2 == '1);
      if (!req_kind) begin
         dec_b = {27'b0, req_rs2[4:0]};
         case (req_funct3)
            3'b001: begin
               dec_op    = OP_SLL;
               dec_issue = 1'b1;
            end
            3'b101: begin
               dec_op    = req_alt ? OP_SRA : OP_SRL;
               dec_issue = 1'b1;
            end
            default: dec_err = 1'b1;
         endcase
         if (dec_issue && BYPASS_ZERO_SHIFT && (req_rs2[4:0] == 5'd0)) begin
            dec_issue = 1'b0;
            dec_data  = req_rs1;
         end
      end else begin
         case (req_funct3)
            3'b000: begin
               dec_op    = OP_MULS;
               dec_issue = 1'b1;
            end
            3'b001: begin
               dec_op    = OP_MULSH;
               dec_issue = 1'b1;
            end
            3'b011: begin
               dec_op    = OP_MULH;
               dec_issue = 1'b1;
            end
            3'b100: begin
               dec_op = OP_DIV;
               if (rs2_zero)     dec_data = '1;
               else if (div_ovf) dec_data = 32'h8000_0000;
               else              dec_issue = 1'b1;
            end
            3'b110: begin
               dec_op = OP_REM;
               if (rs2_zero)     dec_data = req_rs1;
               else if (div_ovf) dec_data = '0;
               else              dec_issue = 1'b1;
            end
            default: dec_err = 1'b1;
         endcase
      end
   end

   // Sequencer FSM with registered outputs and saturating watchdog
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         wdog         <= '0;
         req_ready    <= 1'b1;
         busy         <= 1'b0;
         mds_in_a     <= '0;
         mds_in_b     <= '0;
         mds_op       <= '0;
         mds_in_valid <= 1'b0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  wb_rd     <= req_rd;
                  if (dec_issue) begin
                     // operands load on accept so they are already valid
                     // during the single ISSUE cycle
                     mds_in_a     <= req_rs1;
                     mds_in_b     <= dec_b;
                     mds_op       <= dec_op;
                     mds_in_valid <= 1'b1;
                     state        <= S_ISSUE;
                  end else begin
                     wb_data  <= dec_data;
                     wb_err   <= dec_err;
                     wb_valid <= 1'b1;
                     state    <= S_RESP;
                  end
               end
            end
            S_ISSUE: begin
               mds_in_valid <= 1'b0;
               wdog         <= '0;
               state        <= S_WAIT;
            end
            S_WAIT: begin
               if (wdog != WDW'(TIMEOUT_CYCLES)) wdog <= wdog + 1'b1;
               if (mds_out_valid) begin
                  wb_data  <= mds_out;
                  wb_err   <= 1'b0;
                  wb_valid <= 1'b1;
                  state    <= S_RESP;
               end else if (wdog >= WDW'(TIMEOUT_CYCLES - 1)) begin
                  wb_data  <= '0;
                  wb_err   <= 1'b1;
                  wb_valid <= 1'b1;
                  state    <= S_RESP;
               end
            end
            S_RESP: begin
               if (wb_ready) begin
                  wb_valid  <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
